serial_frame_receiver: RTL and testbench

//   Downstream consumer of the 4-bit shift register's serial output (S_OUT).

---
 rtl/serial_frame_receiver_pkg.sv | 14 +
 rtl/sfr_sync_fifo.sv | 47 ++++
 rtl/serial_frame_receiver.sv | 136 +++++++++++++
 tb/tb_serial_frame_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and line levels.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_STOP = 2'd3
  } sfr_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/sfr_sync_fifo.sv
// Small synchronous FIFO holding received words; head word is shown combinationally on dout.
// A push while full is accepted only if a pop happens on the same edge.
module sfr_sync_fifo #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: deframes start/data/parity/stop on ENB strobes, buffers good words
// in a FIFO behind a VALID/READY handshake, and pulses PAR_ERR, FRM_ERR or OVERRUN for dropped frames.
//
//   state  | meaning
//   S_IDLE | line idle, waiting for a start bit
//   S_DATA | shifting in DATA_W data bits
//   S_PAR  | sampling the even-parity bit
//   S_STOP | sampling the stop bit, deciding push / error
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENB,
  input  logic              S_IN,
  input  logic              DIR,
  input  logic              READY,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  output logic              BUSY,
  output logic              PAR_ERR,
  output logic              FRM_ERR,
  output logic              OVERRUN
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  sfr_state_t        state;
  sfr_state_t        state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              dir_q;
  logic              par_bad;
  logic              start_go;
  logic              shift_en;
  logic              par_chk;
  logic              stop_chk;
  logic              stop_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;

  assign VALID   = !fifo_empty;
  assign BUSY    = (state != S_IDLE);
  assign pop     = VALID && READY;
  // A same-cycle pop frees a slot, so a full FIFO can still take the incoming word.
  assign stop_ok = stop_chk && (S_IN == IDLE_LEVEL) && !par_bad;
  assign push    = stop_ok && (!fifo_full || pop);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-phase strobes; nothing moves on cycles without ENB.
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    if (ENB) begin
      case (state)
        S_IDLE: begin
          if (S_IN == START_LEVEL) begin
            start_go  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? S_PAR : S_STOP;
        end
        S_PAR: begin
          par_chk   = 1'b1;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          stop_chk  = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Deserializer, parity flag and registered error pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= '0;
      shreg   <= '0;
      dir_q   <= 1'b0;
      par_bad <= 1'b0;
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      PAR_ERR <= stop_chk && (S_IN == IDLE_LEVEL) && par_bad;
      FRM_ERR <= stop_chk && (S_IN != IDLE_LEVEL);
      OVERRUN <= stop_ok && fifo_full && !pop;
      if (start_go) begin
        dir_q   <= DIR;
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (shift_en) begin
        // LSB-first fills from the top so the first bit ends at bit 0 after DATA_W shifts.
        shreg   <= dir_q ? {shreg[DATA_W-2:0], S_IN} : {S_IN, shreg[DATA_W-1:1]};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (par_chk) par_bad <= ((^shreg) != S_IN);
    end
  end

  sfr_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RST_N),
    .push (push),
    .pop  (pop),
    .din  (shreg),
    .dout (DATA_OUT),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed scenarios plus randomized frames, checked against
// a frame-level model (queue of expected words plus expected pulse flags).
module tb_serial_frame_receiver;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 2;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b0;
  logic              ENB   = 1'b0;
  logic              S_IN  = 1'b1;
  logic              DIR   = 1'b0;
  logic              READY = 1'b0;
  logic [DATA_W-1:0] DATA_OUT;
  logic              VALID, BUSY, PAR_ERR, FRM_ERR, OVERRUN;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q[$];
  bit mon_en     = 1'b0;
  bit rand_ready = 1'b0;
  bit exp_busy   = 1'b0;
  bit exp_par    = 1'b0;
  bit exp_frm    = 1'b0;
  bit exp_ovr    = 1'b0;

  always #5 CLK = ~CLK;

  serial_frame_receiver #(
    .DATA_W(DATA_W), .PARITY_EN(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .S_IN(S_IN), .DIR(DIR), .READY(READY),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .BUSY(BUSY),
    .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR), .OVERRUN(OVERRUN)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("valid", VALID, (q.size() != 0));
      if (q.size() != 0) check("data", DATA_OUT, q[0]);
      check("busy", BUSY, exp_busy);
      check("par_err", PAR_ERR, exp_par);
      check("frm_err", FRM_ERR, exp_frm);
      check("overrun", OVERRUN, exp_ovr);
    end
  end

  // One clock: drive inputs, take the edge, apply the model's pop, drop last cycle's pulses.
  task automatic cycle(input logic enb, input logic sin, input int rdy);
    logic [DATA_W-1:0] tmp;
    ENB  = enb;
    S_IN = sin;
    if (rdy >= 0) READY = rdy[0];
    else if (rand_ready) READY = 1'($urandom_range(0, 1));
    @(posedge CLK);
    if (READY && q.size() > 0) tmp = q.pop_front();
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
    #1;
  endtask

  task automatic do_gap(input int n);
    for (int g = 0; g < n; g++) begin
      DIR = 1'($urandom_range(0, 1));
      cycle(1'b0, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  // Send one frame; DIR is only honest on the start cycle and scrambled afterwards.
  task automatic send_frame(input logic [DATA_W-1:0] word, input logic dir, input logic par_flip,
                            input logic stop_bit, input int gap, input int stop_rdy);
    logic parity;
    DIR = dir;
    cycle(1'b1, 1'b0, -1);
    exp_busy = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      do_gap(gap);
      DIR = 1'($urandom_range(0, 1));
      cycle(1'b1, dir ? word[DATA_W-1-i] : word[i], -1);
    end
    parity = (^word) ^ par_flip;
    do_gap(gap);
    cycle(1'b1, parity, -1);
    do_gap(gap);
    cycle(1'b1, stop_bit, stop_rdy);
    exp_busy = 1'b0;
    if (!stop_bit)              exp_frm = 1'b1;
    else if (par_flip)          exp_par = 1'b1;
    else if (q.size() < DEPTH)  q.push_back(word);
    else                        exp_ovr = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, -1);
  endtask

  initial begin
    // Reset then idle
    RST_N = 1'b0; ENB = 1'b1; S_IN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      check("rst_valid", VALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_data", DATA_OUT, 0);
      check("rst_pulses", {PAR_ERR, FRM_ERR, OVERRUN}, 0);
    end
    RST_N = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // LSB-first and MSB-first decode of the same bit stream 1,0,1,1
    READY = 1'b1;
    send_frame(4'hD, 1'b0, 1'b0, 1'b1, 0, -1);
    check("lsb_data", DATA_OUT, 4'hD);
    check("lsb_valid", VALID, 1);
    idle(1);
    check("lsb_valid_gone", VALID, 0);
    send_frame(4'hB, 1'b1, 1'b0, 1'b1, 0, -1);
    check("msb_data", DATA_OUT, 4'hB);
    idle(2);
    send_frame(4'hB, 1'b1, 1'b0, 1'b1, 2, -1);
    check("msb_gap_data", DATA_OUT, 4'hB);
    check("msb_gap_valid", VALID, 1);
    idle(2);

    // Parity error and framing error
    send_frame(4'h3, 1'b0, 1'b1, 1'b1, 0, -1);
    check("par_pulse", PAR_ERR, 1);
    check("par_no_valid", VALID, 0);
    idle(1);
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 0, -1);
    check("frm_pulse", {PAR_ERR, FRM_ERR, OVERRUN}, 3'b010);
    idle(2);

    // Overrun with the consumer stalled, then drain
    READY = 1'b0;
    send_frame(4'h1, 1'b0, 1'b0, 1'b1, 0, -1);
    send_frame(4'h2, 1'b1, 1'b0, 1'b1, 0, -1);
    send_frame(4'h3, 1'b0, 1'b0, 1'b1, 0, -1);
    check("ovr_pulse", OVERRUN, 1);
    check("ovr_head", DATA_OUT, 4'h1);
    READY = 1'b1;
    idle(3);
    check("drained", VALID, 0);

    // Full FIFO with a pop on the stop-sample edge: push succeeds
    READY = 1'b0;
    send_frame(4'h1, 1'b0, 1'b0, 1'b1, 0, -1);
    send_frame(4'h2, 1'b0, 1'b0, 1'b1, 1, -1);
    send_frame(4'h3, 1'b1, 1'b0, 1'b1, 0, 1);
    check("pop_push_ovr", OVERRUN, 0);
    check("pop_push_head", DATA_OUT, 4'h2);
    READY = 1'b0;
    idle(2);
    READY = 1'b1;
    idle(3);
    check("pop_push_drained", VALID, 0);

    // Async reset mid-frame with a word buffered
    READY = 1'b0;
    send_frame(4'h6, 1'b0, 1'b0, 1'b1, 0, -1);
    DIR = 1'b0;
    cycle(1'b1, 1'b0, -1);
    exp_busy = 1'b1;
    cycle(1'b1, 1'b1, -1);
    cycle(1'b1, 1'b0, -1);
    #2;
    RST_N = 1'b0;
    q.delete();
    exp_busy = 1'b0;
    #1;
    check("arst_valid", VALID, 0);
    check("arst_busy", BUSY, 0);
    check("arst_data", DATA_OUT, 0);
    check("arst_pulses", {PAR_ERR, FRM_ERR, OVERRUN}, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idle(2);
    READY = 1'b1;
    send_frame(4'hA, 1'b0, 1'b0, 1'b1, 0, -1);
    check("post_rst_data", DATA_OUT, 4'hA);
    idle(2);

    // Randomized frames, ready and gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 80; f++) begin
      send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 2), -1);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    READY = 1'b1;
    idle(4);
    check("final_empty", VALID, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
